rs_entry: RTL and testbench

//  One reservation-station slot of the out-of-order core. Captures a dispatched instruction
//  (decode packet + map-table tags + ROB operand values), snoops the CDB until both source

---
 rtl/rs_entry_pkg.sv | 52 +++++
 rtl/rs_operand.sv | 67 ++++++
 rtl/rs_entry.sv | 91 +++++++++
 tb/tb_rs_entry.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_entry_pkg.sv
// rtl/rs_entry_pkg.sv - shared widths, packet typedefs and tag helper for the reservation-station entry
package rs_entry_pkg;

  localparam int XLEN      = 32;
  localparam int TAG_W     = 5;
  localparam int ROB_IDX_W = 5;
  localparam int REG_IDX_W = 5;
  localparam int INST_W    = 32;

  // Tag value 0 means "no producer": operand comes from the regfile, or no CDB broadcast.
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic [INST_W-1:0]    inst;
    logic [XLEN-1:0]      rs1_value;
    logic [XLEN-1:0]      rs2_value;
    logic [REG_IDX_W-1:0] dest_reg_idx;
  } ID_PACKET;

  typedef struct packed {
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs1_ready;
    logic             rs2_ready;
  } MT2RS_PACKET;

  typedef struct packed {
    logic [TAG_W-1:0] reg_tag;
    logic [XLEN-1:0]  reg_value;
  } CDB_PACKET;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_entry;
    logic [XLEN-1:0]      rs1_value;
    logic [XLEN-1:0]      rs2_value;
  } ROB2RS_PACKET;

  typedef struct packed {
    logic [INST_W-1:0]    inst;
    logic [REG_IDX_W-1:0] dest_reg_idx;
    logic [ROB_IDX_W-1:0] rob_entry;
    logic [XLEN-1:0]      rs1_value;
    logic [XLEN-1:0]      rs2_value;
  } IS_PACKET;

  // A broadcast tag matches a waiting tag only when it is a real (non-zero) tag.
  function automatic logic tag_match(input logic [TAG_W-1:0] bcast_tag,
                                     input logic [TAG_W-1:0] wait_tag);
    return (bcast_tag != NO_TAG) && (bcast_tag == wait_tag);
  endfunction

endpackage

// File: rtl/rs_operand.sv
// rtl/rs_operand.sv - one source operand slot: tag/value/valid register with CDB snoop (RS_ENTRY_CDB_BYPASS_EN)
module rs_operand
  import rs_entry_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             drop,
  input  logic             busy,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             ready_in,
  input  logic [XLEN-1:0]  id_value,
  input  logic [XLEN-1:0]  rob_value,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  output logic [XLEN-1:0]  value,
  output logic             valid
);

  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  value_q;
  logic             valid_q;
  logic             snoop_hit;

  // Wakeup candidate: entry occupied, operand still missing, and the CDB carries its tag.
  assign snoop_hit = busy & ~valid_q & tag_match(cdb_tag, tag_q);

  // Operand capture on dispatch, invalidate on free, otherwise snoop the CDB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_q   <= NO_TAG;
      value_q <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      tag_q <= tag_in;
      if (tag_in == NO_TAG) begin
        value_q <= id_value;
        valid_q <= 1'b1;
      end else if (ready_in) begin
        value_q <= rob_value;
        valid_q <= 1'b1;
      end else if (tag_match(cdb_tag, tag_in)) begin
        // Producer broadcasts on the same edge we dispatch; catch it now or miss it forever.
        value_q <= cdb_value;
        valid_q <= 1'b1;
      end else begin
        value_q <= '0;
        valid_q <= 1'b0;
      end
    end else if (drop) begin
      valid_q <= 1'b0;
    end else if (snoop_hit) begin
      value_q <= cdb_value;
      valid_q <= 1'b1;
    end
  end

`ifdef RS_ENTRY_CDB_BYPASS_EN
  // Same-cycle wakeup: forward the broadcast value before it is registered.
  assign valid = valid_q | snoop_hit;
  assign value = snoop_hit ? cdb_value : value_q;
`else
  assign valid = valid_q;
  assign value = value_q;
`endif

endmodule

// File: rtl/rs_entry.sv
// rtl/rs_entry.sv - one reservation-station slot: dispatch capture, CDB wakeup, issue packet (RS_ENTRY_CDB_BYPASS_EN)
module rs_entry
  import rs_entry_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  ID_PACKET     id_packet_in,
  input  MT2RS_PACKET  mt2rs_packet_in,
  input  CDB_PACKET    cdb_packet_in,
  input  ROB2RS_PACKET rob2rs_packet_in,
  input  logic         clear,
  input  logic         wr_en,
  output IS_PACKET     entry_packet,
  output logic         busy,
  output logic         ready
);

  logic                 busy_q;
  logic [INST_W-1:0]    inst_q;
  logic [REG_IDX_W-1:0] dest_q;
  logic [ROB_IDX_W-1:0] rob_q;
  logic                 drop;
  logic [XLEN-1:0]      rs1_value;
  logic [XLEN-1:0]      rs2_value;
  logic                 rs1_valid;
  logic                 rs2_valid;

  // A load in the same cycle as clear wins, so the slot can be reused back to back.
  assign drop = clear & ~wr_en;

  // Occupancy and the non-operand fields of the instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      inst_q <= '0;
      dest_q <= '0;
      rob_q  <= '0;
    end else if (wr_en) begin
      busy_q <= 1'b1;
      inst_q <= id_packet_in.inst;
      dest_q <= id_packet_in.dest_reg_idx;
      rob_q  <= rob2rs_packet_in.rob_entry;
    end else if (drop) begin
      busy_q <= 1'b0;
    end
  end

  rs_operand u_src1 (
    .clock     (clock),
    .reset     (reset),
    .load      (wr_en),
    .drop      (drop),
    .busy      (busy_q),
    .tag_in    (mt2rs_packet_in.rs1_tag),
    .ready_in  (mt2rs_packet_in.rs1_ready),
    .id_value  (id_packet_in.rs1_value),
    .rob_value (rob2rs_packet_in.rs1_value),
    .cdb_tag   (cdb_packet_in.reg_tag),
    .cdb_value (cdb_packet_in.reg_value),
    .value     (rs1_value),
    .valid     (rs1_valid)
  );

  rs_operand u_src2 (
    .clock     (clock),
    .reset     (reset),
    .load      (wr_en),
    .drop      (drop),
    .busy      (busy_q),
    .tag_in    (mt2rs_packet_in.rs2_tag),
    .ready_in  (mt2rs_packet_in.rs2_ready),
    .id_value  (id_packet_in.rs2_value),
    .rob_value (rob2rs_packet_in.rs2_value),
    .cdb_tag   (cdb_packet_in.reg_tag),
    .cdb_value (cdb_packet_in.reg_value),
    .value     (rs2_value),
    .valid     (rs2_valid)
  );

  // Issue view of the slot; operand validity only matters while busy.
  always_comb begin
    busy                      = busy_q;
    ready                     = busy_q & rs1_valid & rs2_valid;
    entry_packet.inst         = inst_q;
    entry_packet.dest_reg_idx = dest_q;
    entry_packet.rob_entry    = rob_q;
    entry_packet.rs1_value    = rs1_value;
    entry_packet.rs2_value    = rs2_value;
  end

endmodule

// File: tb/tb_rs_entry.sv
// tb/tb_rs_entry.sv - directed and randomized self-checking bench for rs_entry
module tb_rs_entry;
  import rs_entry_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  ID_PACKET     id_in;
  MT2RS_PACKET  mt_in;
  CDB_PACKET    cdb_in;
  ROB2RS_PACKET rob_in;
  logic         clear;
  logic         wr_en;
  IS_PACKET     entry_packet;
  logic         busy;
  logic         ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: an occupied flag, instruction fields, and per-source {known, value, tag}.
  logic                 m_busy;
  logic [INST_W-1:0]    m_inst;
  logic [REG_IDX_W-1:0] m_dest;
  logic [ROB_IDX_W-1:0] m_rob;
  logic                 m_known [2];
  logic [XLEN-1:0]      m_val   [2];
  logic [TAG_W-1:0]     m_tag   [2];

  rs_entry dut (
    .clock            (clock),
    .reset            (reset),
    .id_packet_in     (id_in),
    .mt2rs_packet_in  (mt_in),
    .cdb_packet_in    (cdb_in),
    .rob2rs_packet_in (rob_in),
    .clear            (clear),
    .wr_en            (wr_en),
    .entry_packet     (entry_packet),
    .busy             (busy),
    .ready            (ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [TAG_W-1:0] in_tag(input int i);
    return (i == 0) ? mt_in.rs1_tag : mt_in.rs2_tag;
  endfunction
  function automatic logic in_rdy(input int i);
    return (i == 0) ? mt_in.rs1_ready : mt_in.rs2_ready;
  endfunction
  function automatic logic [XLEN-1:0] in_id(input int i);
    return (i == 0) ? id_in.rs1_value : id_in.rs2_value;
  endfunction
  function automatic logic [XLEN-1:0] in_rob(input int i);
    return (i == 0) ? rob_in.rs1_value : rob_in.rs2_value;
  endfunction
  function automatic logic [XLEN-1:0] obs_val(input int i);
    return (i == 0) ? entry_packet.rs1_value : entry_packet.rs2_value;
  endfunction

  // Is the CDB right now broadcasting the value source i is waiting for?
  function automatic logic cdb_feeds(input int i);
    return m_busy && !m_known[i] && cdb_in.reg_tag != 0 && cdb_in.reg_tag == m_tag[i];
  endfunction

  function automatic logic src_ok(input int i);
`ifdef RS_ENTRY_CDB_BYPASS_EN
    return m_known[i] || cdb_feeds(i);
`else
    return m_known[i];
`endif
  endfunction

  function automatic logic [XLEN-1:0] src_val(input int i);
`ifdef RS_ENTRY_CDB_BYPASS_EN
    if (!m_known[i] && cdb_feeds(i)) return cdb_in.reg_value;
`endif
    return m_val[i];
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_inst = '0; m_dest = '0; m_rob = '0;
    for (int i = 0; i < 2; i++) begin
      m_known[i] = 1'b0; m_val[i] = '0; m_tag[i] = '0;
    end
  endtask

  task automatic check_all();
    chk("busy", 64'(busy), 64'(m_busy));
    chk("ready", 64'(ready), 64'(m_busy && src_ok(0) && src_ok(1)));
    if (m_busy) begin
      chk("inst", 64'(entry_packet.inst), 64'(m_inst));
      chk("dest", 64'(entry_packet.dest_reg_idx), 64'(m_dest));
      chk("rob_entry", 64'(entry_packet.rob_entry), 64'(m_rob));
      for (int i = 0; i < 2; i++)
        if (src_ok(i)) chk(i == 0 ? "rs1_value" : "rs2_value", 64'(obs_val(i)), 64'(src_val(i)));
    end
  endtask

  // One clock edge: work out what the slot should hold, let the DUT take the edge, compare.
  task automatic step();
    logic                 n_busy = m_busy;
    logic [INST_W-1:0]    n_inst = m_inst;
    logic [REG_IDX_W-1:0] n_dest = m_dest;
    logic [ROB_IDX_W-1:0] n_rob  = m_rob;
    logic                 n_known [2];
    logic [XLEN-1:0]      n_val   [2];
    logic [TAG_W-1:0]     n_tag   [2];
    for (int i = 0; i < 2; i++) begin
      n_known[i] = m_known[i]; n_val[i] = m_val[i]; n_tag[i] = m_tag[i];
    end
    if (wr_en) begin
      n_busy = 1'b1;
      n_inst = id_in.inst;
      n_dest = id_in.dest_reg_idx;
      n_rob  = rob_in.rob_entry;
      for (int i = 0; i < 2; i++) begin
        n_tag[i] = in_tag(i);
        if (in_tag(i) == 0)                                      begin n_known[i] = 1; n_val[i] = in_id(i); end
        else if (in_rdy(i))                                      begin n_known[i] = 1; n_val[i] = in_rob(i); end
        else if (cdb_in.reg_tag != 0 && cdb_in.reg_tag == in_tag(i)) begin n_known[i] = 1; n_val[i] = cdb_in.reg_value; end
        else n_known[i] = 0;
      end
    end else if (clear) begin
      n_busy = 1'b0;
      n_known[0] = 0; n_known[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (cdb_feeds(i)) begin n_known[i] = 1; n_val[i] = cdb_in.reg_value; end
    end
    @(posedge clock);
    #1;
    m_busy = n_busy; m_inst = n_inst; m_dest = n_dest; m_rob = n_rob;
    for (int i = 0; i < 2; i++) begin
      m_known[i] = n_known[i]; m_val[i] = n_val[i]; m_tag[i] = n_tag[i];
    end
    check_all();
  endtask

  task automatic idle_inputs();
    wr_en = 0; clear = 0;
    cdb_in = '0;
  endtask

  task automatic load(input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                      input logic r1, input logic r2);
    wr_en = 1;
    mt_in.rs1_tag = t1; mt_in.rs2_tag = t2;
    mt_in.rs1_ready = r1; mt_in.rs2_ready = r2;
  endtask

  initial begin
    reset = 0;
    id_in = '0; mt_in = '0; cdb_in = '0; rob_in = '0;
    clear = 0; wr_en = 0;
    model_reset();
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_packet", 64'(entry_packet.inst) ^ 64'(entry_packet.rs1_value) ^ 64'(entry_packet.rs2_value)
        ^ 64'(entry_packet.rob_entry) ^ 64'(entry_packet.dest_reg_idx), 64'd0);
    @(posedge clock); #1;
    reset = 1;

    // 1: regfile operands, then free
    id_in.inst = 32'hABCDEF12; id_in.rs1_value = 1; id_in.rs2_value = 1; id_in.dest_reg_idx = 5'd3;
    load(0, 0, 0, 0);
    step();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_ready", 64'(ready), 64'd1);
    chk("t1_inst", 64'(entry_packet.inst), 64'hABCDEF12);
    idle_inputs(); clear = 1;
    step();
    chk("t1_clr_busy", 64'(busy), 64'd0);
    chk("t1_clr_ready", 64'(ready), 64'd0);

    // 2: operands already in the ROB
    idle_inputs();
    rob_in.rs1_value = 7; rob_in.rs2_value = 9; rob_in.rob_entry = 5'd4;
    load(1, 1, 1, 1);
    step();
    chk("t2_ready", 64'(ready), 64'd1);
    chk("t2_rs1", 64'(entry_packet.rs1_value), 64'd7);
    chk("t2_rs2", 64'(entry_packet.rs2_value), 64'd9);

    // 3: one operand waits, woken by the CDB
    load(2, 3, 0, 1);
    step();
    chk("t3_wait_ready", 64'(ready), 64'd0);
    idle_inputs(); cdb_in.reg_tag = 2; cdb_in.reg_value = 10;
    step();
    chk("t3_wake_ready", 64'(ready), 64'd1);
    chk("t3_wake_rs1", 64'(entry_packet.rs1_value), 64'd10);

    // 4: both operands wait, woken one at a time
    idle_inputs(); load(3, 4, 0, 0);
    step();
    idle_inputs(); cdb_in.reg_tag = 4; cdb_in.reg_value = 10;
    step();
    chk("t4_half_ready", 64'(ready), 64'd0);
    cdb_in.reg_tag = 3;
    step();
    chk("t4_full_ready", 64'(ready), 64'd1);

    // 5: reuse the slot with load and clear on the same edge
    idle_inputs(); clear = 1; rob_in.rob_entry = 5'd17;
    load(1, 1, 1, 1);
    step();
    chk("t5_busy", 64'(busy), 64'd1);
    chk("t5_ready", 64'(ready), 64'd1);
    chk("t5_rob", 64'(entry_packet.rob_entry), 64'd17);

    // 6: zero-tag broadcast never wakes; async reset mid-wait
    idle_inputs(); load(2, 2, 0, 0);
    step();
    idle_inputs(); cdb_in.reg_tag = 0; cdb_in.reg_value = 32'h55;
    step();
    chk("t6_notag_ready", 64'(ready), 64'd0);
    chk("t6_notag_busy", 64'(busy), 64'd1);
    #2;
    reset = 0;
    #1;
    model_reset();
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_ready", 64'(ready), 64'd0);
    @(posedge clock); #1;
    reset = 1;

    // Randomized traffic over a small tag space so matches are frequent.
    for (int n = 0; n < 400; n++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 7) == 0);
      id_in.inst = $urandom; id_in.rs1_value = $urandom; id_in.rs2_value = $urandom;
      id_in.dest_reg_idx = 5'($urandom);
      mt_in.rs1_tag = 5'($urandom_range(0, 3)); mt_in.rs2_tag = 5'($urandom_range(0, 3));
      mt_in.rs1_ready = 1'($urandom); mt_in.rs2_ready = 1'($urandom);
      rob_in.rob_entry = 5'($urandom); rob_in.rs1_value = $urandom; rob_in.rs2_value = $urandom;
      cdb_in.reg_tag = 5'($urandom_range(0, 3)); cdb_in.reg_value = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
